// File: rtl/arb_req_queue.sv
// Requester-side agent for one arbiter port: queues outbound payloads, requests while
// non-empty, pops on grant, and flags requests that have waited too long.
module arb_req_queue #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned STARVE_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      wr_valid_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    output logic                      wr_ready_o,
    output logic                      req_o,
    input  logic                      gnt_i,
    output logic                      gnt_valid_o,
    output logic [DATA_W-1:0]         gnt_data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      starved_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = $clog2(STARVE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                push, pop;

    // Handshake outputs depend only on registered state, never on gnt_i.
    assign req_o      = (state_q != S_EMPTY);
    assign wr_ready_o = (state_q != S_FULL);
    assign count_o    = count_q;

    assign push = wr_valid_i && wr_ready_o;
    assign pop  = req_o && gnt_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_EMPTY;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wait_q      <= '0;
            gnt_valid_o <= 1'b0;
            gnt_data_o  <= '0;
            starved_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wait_q      <= wait_d;
            gnt_valid_o <= pop;
            starved_o   <= (wait_d == WAIT_W'(STARVE_CYCLES));
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                gnt_data_o <= mem[rd_ptr_q];
            end
        end
    end

    // Payload storage carries no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wait_d  = wait_q;

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    state_d = S_PARTIAL;
                end
            end
            S_PARTIAL: begin
                if (push && !pop && (count_q == CNT_W'(DEPTH - 1))) begin
                    state_d = S_FULL;
                end else if (pop && !push && (count_q == CNT_W'(1))) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    state_d = S_PARTIAL;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Starvation counter saturates; any pop or idle cycle restarts it.
        if (!req_o || pop) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(STARVE_CYCLES)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue: table of per-cycle vectors plus hand-written corner sequences,
// with a queue model and grant scoreboard checked every cycle.
module tb_arb_req_queue;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned STARVE = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic              req;
    logic              gnt = 1'b0;
    logic              gnt_valid;
    logic [DATA_W-1:0] gnt_data;
    logic [$clog2(DEPTH):0] count;
    logic              starved;

    arb_req_queue #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_CYCLES(STARVE)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .req_o(req), .gnt_i(gnt),
        .gnt_valid_o(gnt_valid), .gnt_data_o(gnt_data),
        .count_o(count), .starved_o(starved)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DATA_W-1:0] m_fifo[$];
    logic [DATA_W-1:0] exp_q[$];
    int                m_count = 0;
    int                m_wait  = 0;
    bit                m_pop   = 1'b0;
    logic [DATA_W-1:0] m_gd    = '0;

    typedef struct {
        bit          wv;
        logic [7:0]  wd;
        bit          g;
        int          exp_count;
        bit          exp_req;
        bit          exp_ready;
        bit          exp_gv;
        logic [7:0]  exp_gd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_count = 0;
        m_wait  = 0;
        m_pop   = 1'b0;
        m_gd    = '0;
    endtask

    // One clock: drive at negedge, check model after the rising edge.
    task automatic cycle(input bit wv, input logic [7:0] wd, input bit g);
        bit push;
        bit pop;
        @(negedge clk);
        wr_valid = wv;
        wr_data  = wd;
        gnt      = g;
        push = wv && (m_count < int'(DEPTH));
        pop  = (m_count != 0) && g;
        @(posedge clk);
        #1;
        if (m_count == 0 || pop) m_wait = 0;
        else if (m_wait < int'(STARVE)) m_wait++;
        if (pop) exp_q.push_back(m_fifo.pop_front());
        if (push) m_fifo.push_back(wd);
        m_count = m_fifo.size();
        m_pop   = pop;

        chk("count", 32'(count), 32'(m_count));
        chk("req", 32'(req), 32'(m_count != 0));
        chk("wr_ready", 32'(wr_ready), 32'(m_count < int'(DEPTH)));
        chk("starved", 32'(starved), 32'(m_wait == int'(STARVE)));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_pop));
        if (gnt_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL gnt_scoreboard: got pulse data %0h expected no pulse", gnt_data);
            end else begin
                m_gd = exp_q.pop_front();
            end
        end
        chk("gnt_data", 32'(gnt_data), 32'(m_gd));
    endtask

    vec_t vecs[$];

    initial begin
        // Single entry, full/refused push (incl. push during pop at full), drain, idle grants.
        vecs.push_back('{1, 8'hA5, 0, 1, 1, 1, 0, 8'h00});
        vecs.push_back('{0, 8'h00, 1, 0, 0, 1, 1, 8'hA5});
        vecs.push_back('{1, 8'h11, 0, 1, 1, 1, 0, 8'h00});
        vecs.push_back('{1, 8'h22, 0, 2, 1, 1, 0, 8'h00});
        vecs.push_back('{1, 8'h33, 0, 3, 1, 1, 0, 8'h00});
        vecs.push_back('{1, 8'h44, 0, 4, 1, 0, 0, 8'h00});
        vecs.push_back('{1, 8'h55, 0, 4, 1, 0, 0, 8'h00});
        vecs.push_back('{1, 8'h66, 1, 3, 1, 1, 1, 8'h11});
        vecs.push_back('{0, 8'h00, 1, 2, 1, 1, 1, 8'h22});
        vecs.push_back('{0, 8'h00, 1, 1, 1, 1, 1, 8'h33});
        vecs.push_back('{0, 8'h00, 1, 0, 0, 1, 1, 8'h44});
        for (int i = 0; i < 5; i++) vecs.push_back('{0, 8'h00, 1, 0, 0, 1, 0, 8'h00});

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("rst_gnt_data", 32'(gnt_data), 32'd0);
        chk("rst_starved", 32'(starved), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].wv, vecs[i].wd, vecs[i].g);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("tbl%0d_req", i), 32'(req), 32'(vecs[i].exp_req));
            chk($sformatf("tbl%0d_ready", i), 32'(wr_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("tbl%0d_gv", i), 32'(gnt_valid), 32'(vecs[i].exp_gv));
            if (vecs[i].exp_gv) chk($sformatf("tbl%0d_gd", i), 32'(gnt_data), 32'(vecs[i].exp_gd));
        end
        chk("gnt_data_hold", 32'(gnt_data), 32'h44);

        // Simultaneous push and pop at count 2, wrapping pointers several times.
        cycle(1, 8'h70, 0);
        cycle(1, 8'h71, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 8'(8'h80 + i), 1);
            chk("overlap_count", 32'(count), 32'd2);
        end
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 1);
        chk("overlap_last", 32'(gnt_data), 32'h89);
        chk("overlap_empty", 32'(req), 32'd0);

        // Starvation: one entry, 16 un-granted cycles, then a grant.
        cycle(1, 8'hC3, 0);
        for (int i = 1; i <= int'(STARVE); i++) begin
            cycle(0, 8'h00, 0);
            if (i == int'(STARVE) - 1) chk("starve_before", 32'(starved), 32'd0);
        end
        chk("starve_set", 32'(starved), 32'd1);
        cycle(0, 8'h00, 0);
        chk("starve_hold", 32'(starved), 32'd1);
        cycle(0, 8'h00, 1);
        chk("starve_clear", 32'(starved), 32'd0);
        chk("starve_gd", 32'(gnt_data), 32'hC3);

        // Asynchronous reset mid-cycle with 3 queued entries and wait counter at 7.
        cycle(1, 8'hD1, 0);
        cycle(1, 8'hD2, 0);
        cycle(1, 8'hD3, 0);
        for (int i = 0; i < 5; i++) cycle(0, 8'h00, 0);
        chk("pre_rst_count", 32'(count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req", 32'(req), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_starved", 32'(starved), 32'd0);
        chk("arst_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("arst_ready", 32'(wr_ready), 32'd1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(1, 8'h5A, 0);
        cycle(0, 8'h00, 1);
        chk("post_rst_gv", 32'(gnt_valid), 32'd1);
        chk("post_rst_gd", 32'(gnt_data), 32'h5A);
        cycle(0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_req_queue.md
Name: arb_req_queue

Overview:
- Requester-side agent for one port of the fixed-priority arbiter.
- Buffers outbound request payloads in a small FIFO and holds `req_o` high while the FIFO is non-empty.
- Pops the head entry on each cycle the arbiter grants, and delivers the granted payload on a registered output.
- Tracks starvation (request held without grant) for debug and software visibility.

Parameters:
- DATA_W, 8: payload width in bits.
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- STARVE_CYCLES, 16: consecutive un-granted request cycles that set `starved_o`; minimum 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- wr_valid_i  input  1  payload push request from the local client.
- wr_data_i  input  DATA_W  payload to enqueue.
- wr_ready_o  output  1  FIFO can accept a push this cycle.
- req_o  output  1  request line to the arbiter's `req_i` bit.
- gnt_i  input  1  grant bit from the arbiter's one-hot `gnt_o`.
- gnt_valid_o  output  1  one-cycle pulse: a granted payload is on `gnt_data_o`.
- gnt_data_o  output  DATA_W  payload granted in the previous cycle.
- count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.
- starved_o  output  1  request has waited STARVE_CYCLES cycles without a grant.

Behaviour:
- Reset (asynchronous, `reset_i`=1):
  - Read/write pointers, count and wait counter go to 0.
  - `req_o`=0, `gnt_valid_o`=0, `gnt_data_o`=0, `starved_o`=0, `wr_ready_o`=1.
  - FIFO contents are discarded. Reset mid-operation drops all queued entries; no pending grant pulse survives reset.
- Output derivation:
  - `wr_ready_o` = (count < DEPTH). Combinational from registered count only; no combinational path from `gnt_i`.
  - `req_o` = (count != 0). Combinational from registered count only.
  - The arbiter is combinational, so `gnt_i` may depend on `req_o` in the same cycle. No path from `gnt_i` back to `req_o` is permitted.
- Push: occurs when `wr_valid_i` && `wr_ready_o`. Writes `wr_data_i` at the write pointer; pointer increments, wrapping modulo DEPTH.
- Pop: occurs when `req_o` && `gnt_i`. The head entry is removed; read pointer increments, wrapping modulo DEPTH.
- `gnt_i`=1 while `req_o`=0 is ignored: no pop, no pulse, no error.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full case: `wr_ready_o`=0, so no push is accepted even if a pop happens in the same cycle. There is no full-bypass; the freed slot becomes visible the next cycle.
- Empty case: a push raises `req_o` on the next cycle. Minimum push-to-request latency is 1 cycle. The FIFO has no empty-bypass.
- Grant output is registered:
  - On the cycle after a pop, `gnt_valid_o`=1 and `gnt_data_o` = the popped head entry.
  - Otherwise `gnt_valid_o`=0 and `gnt_data_o` holds its last value.
  - Back-to-back pops give consecutive `gnt_valid_o` pulses in FIFO order.
- Starvation counter (`wait_cnt`), width $clog2(STARVE_CYCLES+1):
  - If `req_o`=1 and `gnt_i`=0: increment, saturating at STARVE_CYCLES.
  - If a pop occurs, or `req_o`=0: clear to 0.
  - `starved_o` is registered: `starved_o` = (`wait_cnt` == STARVE_CYCLES). It asserts on the first cycle the counter reaches saturation and deasserts the cycle after the clearing event.
- The FIFO is a state machine on count. The states are EMPTY (0), PARTIAL (1..DEPTH-1) and FULL (DEPTH); transitions follow the push/pop rules above.
- Pointer width is $clog2(DEPTH). Count width is one bit wider, so count can represent DEPTH.

Test Plan:
- Reset, then push 0xA5 with `gnt_i`=0 → next cycle `req_o`=1, `count_o`=1. Raise `gnt_i` for 1 cycle → next cycle `gnt_valid_o`=1, `gnt_data_o`=0xA5, `count_o`=0, `req_o`=0.
- Push 0x11, 0x22, 0x33, 0x44 back-to-back with `gnt_i`=0 → `count_o`=4, `wr_ready_o`=0. A fifth push of 0x55 is refused and `count_o` stays 4. Hold `gnt_i`=1 for 4 cycles → pulses carry 0x11, 0x22, 0x33, 0x44 in order, then `req_o`=0.
- FIFO at count 2 with push and pop in the same cycle → `count_o` stays 2; pointer wrap is exercised over 10 such cycles with data order preserved.
- One entry queued, `gnt_i`=0 for 16 cycles → `starved_o` rises on the cycle after the 16th un-granted cycle. Grant 1 cycle → `starved_o`=0 on the following cycle.
- `gnt_i`=1 with FIFO empty for 5 cycles → `gnt_valid_o` stays 0 and `count_o` stays 0.
- 3 entries queued and `wait_cnt`=7, then assert `reset_i` asynchronously mid-cycle → `req_o`, `count_o`, `starved_o` and `gnt_valid_o` go to 0 immediately. After release, the first push is granted with correct data.
